// File: rtl/wb_sched.sv
// rtl/wb_sched.sv - writeback slot scheduler with hazard detection (optional bypass: WB_SCHED_BYPASS_EN)
//
// slot k holds the instruction that writes back k cycles from now; slot 0 is
// the current writeback. An instruction of latency L lands in slot L-1, so it
// reaches wb_valid_o exactly L cycles after issue.
module wb_sched #(
  parameter int MAX_STAGES = 4,
  parameter int LAT_W      = $clog2(MAX_STAGES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_valid_i,
  input  logic [LAT_W-1:0] issue_lat_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [4:0]       rd_i,
  input  logic             rd_we_i,
  input  logic             flush_i,
  output logic             issue_ready_o,
  output logic             stall_struct_o,
  output logic             stall_raw_o,
  output logic             stall_waw_o,
  output logic             lat_err_o,
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_o,
  output logic             bypass_rs1_o,
  output logic             bypass_rs2_o,
  output logic [LAT_W-1:0] occupancy_o
);

  logic [MAX_STAGES-1:0] slot_valid_q, slot_valid_d;
  logic [MAX_STAGES-1:0] slot_we_q, slot_we_d;
  logic [4:0]            slot_rd_q [MAX_STAGES];
  logic [4:0]            slot_rd_d [MAX_STAGES];

  logic lat_ok;
  logic struct_hit;
  logic raw_hit;
  logic waw_hit;
  logic issue_fire;
  logic [LAT_W-1:0] occ_cnt;
`ifdef WB_SCHED_BYPASS_EN
  logic byp1_hit;
  logic byp2_hit;
`endif

  assign lat_ok    = (issue_lat_i != '0) && (issue_lat_i <= LAT_W'(MAX_STAGES));
  assign lat_err_o = issue_valid_i & ~lat_ok;

  // Hazard scan: every slot is compared against the presented instruction.
  always_comb begin
    struct_hit = 1'b0;
    raw_hit    = 1'b0;
    waw_hit    = 1'b0;
`ifdef WB_SCHED_BYPASS_EN
    byp1_hit   = 1'b0;
    byp2_hit   = 1'b0;
`endif
    for (int k = 0; k < MAX_STAGES; k++) begin
      // Slot L shifts into slot L-1 at the next edge, exactly where the new entry goes.
      if (slot_valid_q[k] && (LAT_W'(k) == issue_lat_i)) begin
        struct_hit = 1'b1;
      end
      if (slot_valid_q[k] && slot_we_q[k] && (slot_rd_q[k] != 5'd0)) begin
        // An older write at or after the new one's writeback would overwrite it.
        if (rd_we_i && (rd_i == slot_rd_q[k]) && (LAT_W'(k) >= issue_lat_i)) begin
          waw_hit = 1'b1;
        end
        if ((rs1_i == slot_rd_q[k]) || (rs2_i == slot_rd_q[k])) begin
`ifdef WB_SCHED_BYPASS_EN
          // Slot 0 is being written back this cycle, so its value is forwarded.
          if (k == 0) begin
            byp1_hit = (rs1_i == slot_rd_q[k]);
            byp2_hit = (rs2_i == slot_rd_q[k]);
          end else begin
            raw_hit = 1'b1;
          end
`else
          raw_hit = 1'b1;
`endif
        end
      end
    end
  end

  assign stall_struct_o = issue_valid_i & struct_hit;
  assign stall_raw_o    = issue_valid_i & raw_hit;
  assign stall_waw_o    = issue_valid_i & waw_hit;

`ifdef WB_SCHED_BYPASS_EN
  assign bypass_rs1_o = byp1_hit;
  assign bypass_rs2_o = byp2_hit;
`else
  assign bypass_rs1_o = 1'b0;
  assign bypass_rs2_o = 1'b0;
`endif

  assign issue_ready_o = ~rst_i & ~flush_i & ~lat_err_o & ~stall_struct_o
                       & ~stall_raw_o & ~stall_waw_o;
  assign issue_fire    = issue_valid_i & issue_ready_o;

  // Next slot contents: shift toward writeback, then drop in the accepted issue.
  always_comb begin
    for (int k = 0; k < MAX_STAGES - 1; k++) begin
      slot_valid_d[k] = slot_valid_q[k+1];
      slot_we_d[k]    = slot_we_q[k+1];
      slot_rd_d[k]    = slot_rd_q[k+1];
    end
    slot_valid_d[MAX_STAGES-1] = 1'b0;
    slot_we_d[MAX_STAGES-1]    = 1'b0;
    slot_rd_d[MAX_STAGES-1]    = 5'd0;
    if (issue_fire) begin
      for (int k = 0; k < MAX_STAGES; k++) begin
        if (LAT_W'(k + 1) == issue_lat_i) begin
          slot_valid_d[k] = 1'b1;
          slot_we_d[k]    = rd_we_i;
          slot_rd_d[k]    = rd_i;
        end
      end
    end
  end

  // Slot registers; reset and flush both discard everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      slot_valid_q <= '0;
      slot_we_q    <= '0;
      for (int k = 0; k < MAX_STAGES; k++) begin
        slot_rd_q[k] <= 5'd0;
      end
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_we_q    <= slot_we_d;
      for (int k = 0; k < MAX_STAGES; k++) begin
        slot_rd_q[k] <= slot_rd_d[k];
      end
    end
  end

  // Population count of occupied slots.
  always_comb begin
    occ_cnt = '0;
    for (int k = 0; k < MAX_STAGES; k++) begin
      occ_cnt = occ_cnt + LAT_W'(slot_valid_q[k]);
    end
  end

  assign occupancy_o = occ_cnt;
  assign wb_valid_o  = slot_valid_q[0];
  assign wb_rd_o     = slot_rd_q[0];

endmodule

// File: doc/wb_sched.md
WB_SCHED -- requirements
Module: wb_sched

Interface
- REQ-001 SHALL have parameter MAX_STAGES, default 4, meaning the deepest execute latency in cycles (legal range 2..8).
- REQ-002 SHALL have parameter LAT_W, default $clog2(MAX_STAGES+1), meaning the width of the latency field.
- REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
- REQ-005 SHALL have port issue_valid_i, input, 1 bit: decode presents an instruction.
- REQ-006 SHALL have port issue_lat_i, input, LAT_W bits: execute latency L of the presented instruction.
- REQ-007 SHALL have ports rs1_i and rs2_i, input, 5 bits each: source register addresses.
- REQ-008 SHALL have port rd_i, input, 5 bits, and port rd_we_i, input, 1 bit: destination address and write enable.
- REQ-009 SHALL have port flush_i, input, 1 bit: kill all in-flight entries.
- REQ-010 SHALL have port issue_ready_o, output, 1 bit: instruction accepted this cycle if issue_valid_i is also high.
- REQ-011 SHALL have ports stall_struct_o, stall_raw_o, stall_waw_o, and lat_err_o, output, 1 bit each: stall causes.
- REQ-012 SHALL have port wb_valid_o, output, 1 bit, and port wb_rd_o, output, 5 bits: writeback slot occupied this cycle, and its rd.
- REQ-013 SHALL have ports bypass_rs1_o and bypass_rs2_o, output, 1 bit each: source operand is taken from this cycle's writeback.
- REQ-014 SHALL have port occupancy_o, output, LAT_W bits: number of valid slots.

Function
- REQ-015 SHALL hold slot_q[0..MAX_STAGES-1], each entry holding {valid, rd, we}, where slot index k is the number of cycles until writeback.
- REQ-016 SHALL, every cycle, shift slot_q[i] <= slot_q[i+1]; slot_q[MAX_STAGES-1] SHALL become empty unless written by an issue.
- REQ-017 SHALL define an issue as firing when issue_valid_i & issue_ready_o; a fired issue SHALL write {1, rd_i, rd_we_i} into slot_q[L-1].
- REQ-018 SHALL drive wb_valid_o and wb_rd_o directly from slot_q[0], giving total latency L cycles from issue to wb_valid_o.
- REQ-019 SHALL assert lat_err_o combinationally when issue_valid_i is high and L==0 or L>MAX_STAGES.
- REQ-020 SHALL assert stall_struct_o when L<MAX_STAGES and slot_q[L].valid, because the shifting entry would collide.
- REQ-021 SHALL assert stall_raw_o when rs1_i or rs2_i equals slot_q[k].rd for any k with valid & we & rd!=0, subject to REQ-030.
- REQ-022 SHALL assert stall_waw_o when rd_we_i and rd_i!=0 and some slot_q[k] with k>=L holds valid & we & the same rd.
- REQ-023 SHALL compute issue_ready_o = !rst_i & !flush_i & !lat_err_o & !stall_struct_o & !stall_raw_o & !stall_waw_o.
- REQ-024 SHALL drive every stall output low whenever issue_valid_i is low.
- REQ-025 SHALL, on flush_i, clear every slot at the next edge and ignore any issue in that cycle; wb_valid_o in the flush cycle SHALL still reflect the current slot_q[0].
- REQ-026 SHALL compute occupancy_o as the population count of slot_q valid bits.
- REQ-027 SHALL never allow two entries in one slot; the vacated top slot SHALL be accepted by an L=MAX_STAGES issue at full occupancy.

Reset
- REQ-028 SHALL, while rst_i is high at a clock edge, clear all slots, so that the next cycle shows wb_valid_o=0, wb_rd_o=0, and occupancy_o=0.
- REQ-029 SHALL drive issue_ready_o low while rst_i is high; a reset mid-operation SHALL discard in-flight entries without emitting their writebacks.

Configuration
- REQ-030 With WB_SCHED_BYPASS_EN defined:
  - a RAW match only against slot_q[0] SHALL NOT stall;
  - bypass_rs1_o and bypass_rs2_o SHALL assert for that match (rs!=0, valid & we).
- REQ-031 Without WB_SCHED_BYPASS_EN:
  - a match on slot_q[0] SHALL stall like any other slot;
  - bypass_rs1_o and bypass_rs2_o SHALL be tied 0.

Verification
- REQ-032 Bench SHALL show: issue rd=5 with L=3 at cycle 0 -> wb_valid_o=1 and wb_rd_o=5 at cycle 3 only; occupancy 1,1,1,0.
- REQ-033 Bench SHALL show: issue L=4 at cycle 0, then L=3 at cycle 1 -> stall_struct_o=1 and issue_ready_o=0; at cycle 2 the L=3 issue is accepted.
- REQ-034 Bench SHALL show: pending rd=7 we=1 in slot 2, then issue rs1=7 -> stall_raw_o=1; rs1=0 against pending rd=0 -> no stall.
- REQ-035 Bench SHALL show: rd=9 pending in slot 3, then issue rd=9 with L=2 -> stall_waw_o=1; with L=4 -> accepted.
- REQ-036 Bench SHALL show: rs2 matches slot 0 -> with WB_SCHED_BYPASS_EN, bypass_rs2_o=1 and ready=1; without it, stall_raw_o=1.
- REQ-037 Bench SHALL show: three entries in flight, then flush_i or rst_i -> next cycle occupancy_o=0 and no later wb_valid_o; L=0 -> lat_err_o=1.
